// File: rtl/io_pkg.sv
// Shared definitions for the board I/O conditioning path and the memory block's MMIO decode.
package io_pkg;

  typedef enum logic [1:0] {LO, WAIT_HI, HI, WAIT_LO} db_state_t;

  localparam int NUM_BT   = 5;
  localparam int BT_MID   = 0;
  localparam int BT_UP    = 1;
  localparam int BT_DOWN  = 2;
  localparam int BT_LEFT  = 3;
  localparam int BT_RIGHT = 4;

  localparam logic [31:0] MMIO_BASE = 32'hffff_ff00;

endpackage

// File: rtl/button_filter.sv
// One push button: 2-flop synchroniser, debounce FSM with counter, press pulse and sticky flag.
module button_filter
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WID         = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic sticky
);

  localparam logic [CNT_WID-1:0] CNT_LAST = CNT_WID'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WID-1:0] CNT_ONE  = CNT_WID'(1);

  logic               sync_p0, sync_p1;
  db_state_t          state, state_nx;
  logic [CNT_WID-1:0] cnt, cnt_nx;
  logic               rise_nx;

  // stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // stage p2: debounce state, level and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LO;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      sticky <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      level  <= (state_nx == HI) || (state_nx == WAIT_LO);
      rise   <= rise_nx;
      // a press landing in the same cycle as a clear must not be lost
      sticky <= rise | (sticky & ~clr);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rise_nx  = 1'b0;
    case (state)
      LO: begin
        if (sync_p1) begin
          state_nx = WAIT_HI;
          cnt_nx   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!sync_p1) begin
          state_nx = LO;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = HI;
          cnt_nx   = '0;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      HI: begin
        if (!sync_p1) begin
          state_nx = WAIT_LO;
          cnt_nx   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (sync_p1) begin
          state_nx = HI;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = LO;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = LO;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/io_debounce.sv
// Board input conditioning: synchronised switch bytes plus five independently debounced buttons.
module io_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WID         = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        sw1_raw,
  input  logic [7:0]        sw2_raw,
  input  logic [7:0]        sw3_raw,
  input  logic [NUM_BT-1:0] bt_raw,
  input  logic [NUM_BT-1:0] bt_clr,
  output logic [7:0]        switches1,
  output logic [7:0]        switches2,
  output logic [7:0]        switches3,
  output logic [NUM_BT-1:0] bt_level,
  output logic [NUM_BT-1:0] bt_rise,
  output logic [NUM_BT-1:0] bt_sticky
);

  logic [23:0] sw_p0, sw_p1;

  // stage p0/p1: switches are level inputs, synchronised only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= {sw3_raw, sw2_raw, sw1_raw};
      sw_p1 <= sw_p0;
    end
  end

  assign switches1 = sw_p1[7:0];
  assign switches2 = sw_p1[15:8];
  assign switches3 = sw_p1[23:16];

  for (genvar i = 0; i < NUM_BT; i++) begin : g_bt
    button_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WID        (CNT_WID)
    ) u_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bt_raw[i]),
      .clr   (bt_clr[i]),
      .level (bt_level[i]),
      .rise  (bt_rise[i]),
      .sticky(bt_sticky[i])
    );
  end

endmodule
